// File: rtl/serial_word_receiver_pkg.sv
// Shared types and defaults for the serial word receiver.
package rx_pkg;

    // Receiver framing state: waiting for a frame start, or mid-frame.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Default number of bits per word.
    localparam int DEFAULT_WIDTH = 4;

    // Width of a counter able to hold 0..width bits received.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial input and word output handshake bundle of the receiver.
// master: the environment (serial source plus downstream consumer).
// slave: the receiver itself.
interface serial_word_receiver_if
    import rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output ser_in,
        output ser_valid,
        output frame_start,
        output word_ready,
        input  word_out,
        input  word_valid
    );

    modport slave (
        input  ser_in,
        input  ser_valid,
        input  frame_start,
        input  word_ready,
        output word_out,
        output word_valid
    );
endinterface

// File: rtl/serial_word_receiver_out_buffer.sv
// One-entry valid/ready holding register for completed words.
// A new word is accepted when the slot is empty or being drained in the
// same cycle; otherwise it is dropped and the sticky overrun flag is set.
module rx_out_buffer
    import rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;
    logic             overrun_reg;

    // Load, consume or drop; word_ready only matters while a word is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (load) begin
            if (!valid_reg || word_ready) begin
                word_reg  <= load_word;
                valid_reg <= 1'b1;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (valid_reg && word_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign word_out   = word_reg;
    assign word_valid = valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words framed by
// frame_start and hands them downstream through a one-word buffer.
module serial_word_receiver
    import rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    serial_word_receiver_if.slave            bus,
    output logic [count_width(WIDTH)-1:0]    bit_count,
    output logic                             framing_err,
    output logic                             overrun
);
    localparam int               CW   = count_width(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE  = CW'(1);

    rx_state_t        state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             err_reg, err_next;
    logic             complete;

    // Shift results: continuing the current frame, or starting from an
    // empty register so an aborted partial word cannot leak into the next.
    logic [WIDTH-1:0] shift_cont;
    logic [WIDTH-1:0] shift_fresh;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_cont  = {shreg_reg[WIDTH-2:0], bus.ser_in};
            assign shift_fresh = {{(WIDTH-1){1'b0}}, bus.ser_in};
        end else begin : g_lsb_first
            assign shift_cont  = {bus.ser_in, shreg_reg[WIDTH-1:1]};
            assign shift_fresh = {bus.ser_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // State, shift register, bit counter and framing-error pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Framing FSM: capture qualified bits, restart on frame_start, and
    // flag completion on the WIDTH-th bit of an uninterrupted frame.
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        count_next = count_reg;
        err_next   = 1'b0;
        complete   = 1'b0;
        if (bus.ser_valid) begin
            case (state_reg)
                IDLE: begin
                    if (bus.frame_start) begin
                        shreg_next = shift_fresh;
                        count_next = ONE;
                        state_next = RECV;
                    end
                end
                RECV: begin
                    if (bus.frame_start) begin
                        err_next   = 1'b1;
                        shreg_next = shift_fresh;
                        count_next = ONE;
                    end else begin
                        shreg_next = shift_cont;
                        if (count_reg == LAST) begin
                            complete   = 1'b1;
                            count_next = '0;
                            state_next = IDLE;
                        end else begin
                            count_next = count_reg + ONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    rx_out_buffer #(
        .WIDTH (WIDTH)
    ) u_out_buffer (
        .clock      (clock),
        .reset      (reset),
        .load       (complete),
        .load_word  (shift_cont),
        .word_ready (bus.word_ready),
        .word_out   (bus.word_out),
        .word_valid (bus.word_valid),
        .overrun    (overrun)
    );

    assign bit_count   = count_reg;
    assign framing_err = err_reg;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench: one MSB-first and one LSB-first receiver fed the same stream.
module tb_serial_word_receiver;
    import rx_pkg::*;

    localparam int WIDTH = 4;
    localparam int CW    = count_width(WIDTH);

    logic clock = 1'b0;
    logic reset;
    logic ser_in, ser_valid, frame_start, word_ready;

    logic [CW-1:0] cnt_m, cnt_l;
    logic          err_m, err_l, ovr_m, ovr_l;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_word_receiver_if #(.WIDTH(WIDTH)) bus_m ();
    serial_word_receiver_if #(.WIDTH(WIDTH)) bus_l ();

    assign bus_m.ser_in      = ser_in;
    assign bus_m.ser_valid   = ser_valid;
    assign bus_m.frame_start = frame_start;
    assign bus_m.word_ready  = word_ready;
    assign bus_l.ser_in      = ser_in;
    assign bus_l.ser_valid   = ser_valid;
    assign bus_l.frame_start = frame_start;
    assign bus_l.word_ready  = word_ready;

    serial_word_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_m),
        .bit_count   (cnt_m),
        .framing_err (err_m),
        .overrun     (ovr_m)
    );

    serial_word_receiver #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_l),
        .bit_count   (cnt_l),
        .framing_err (err_l),
        .overrun     (ovr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of serial input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b, input logic s);
        ser_valid   = v;
        ser_in      = b;
        frame_start = s;
        @(posedge clock);
        #1;
    endtask

    // Send a full frame, first element of the array is the first bit on the wire.
    task automatic frame(input logic [WIDTH-1:0] bits_first_at_msb);
        for (int i = WIDTH - 1; i >= 0; i--)
            step(1'b1, bits_first_at_msb[i], i == WIDTH - 1);
        ser_valid = 1'b0;
    endtask

    task automatic words(input string tag, input logic [3:0] em, input logic [3:0] el);
        $display("%s: msb word=%h lsb word=%h valid=%b/%b", tag, bus_m.word_out, bus_l.word_out,
                 bus_m.word_valid, bus_l.word_valid);
        chk({tag, "_word_msb"}, 32'(bus_m.word_out), 32'(em));
        chk({tag, "_word_lsb"}, 32'(bus_l.word_out), 32'(el));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_valid"}, 32'({bus_m.word_valid, bus_l.word_valid}), 32'h0);
        chk({tag, "_word"},  32'({bus_m.word_out, bus_l.word_out}), 32'h0);
        chk({tag, "_count"}, 32'({cnt_m, cnt_l}), 32'h0);
        chk({tag, "_ferr"},  32'({err_m, err_l}), 32'h0);
        chk({tag, "_ovr"},   32'({ovr_m, ovr_l}), 32'h0);
    endtask

    initial begin
        reset = 1'b1; word_ready = 1'b0;
        ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        all_zero("reset");
        reset = 1'b0;

        // Bit without frame_start in IDLE is ignored.
        step(1, 1, 0);
        chk("idle_ignore_count", 32'(cnt_m), 32'd0);

        // Stream 1,0,1,1 back to back, downstream ready.
        word_ready = 1'b1;
        step(1, 1, 1); chk("t1_count1", 32'(cnt_m), 32'd1);
        step(1, 0, 0); chk("t1_count2", 32'(cnt_m), 32'd2);
        step(1, 1, 0); chk("t1_count3", 32'(cnt_m), 32'd3);
        chk("t1_valid_early", 32'(bus_m.word_valid), 32'd0);
        step(1, 1, 0); chk("t1_count0", 32'(cnt_m), 32'd0);
        chk("t1_valid", 32'({bus_m.word_valid, bus_l.word_valid}), 32'h3);
        words("t1", 4'b1011, 4'b1101);
        step(0, 0, 0);
        chk("t1_valid_drop", 32'({bus_m.word_valid, bus_l.word_valid}), 32'h0);
        chk("t1_word_kept", 32'(bus_m.word_out), 32'hB);

        // Same stream with two idle cycles between bits.
        step(1, 1, 1); step(0, 0, 0); step(0, 0, 0);
        chk("t2_count1", 32'(cnt_m), 32'd1);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t2_count2", 32'(cnt_l), 32'd2);
        step(1, 1, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t2_count3", 32'(cnt_m), 32'd3);
        chk("t2_no_valid", 32'(bus_m.word_valid), 32'd0);
        step(1, 1, 0);
        chk("t2_count0", 32'(cnt_m), 32'd0);
        chk("t2_valid", 32'(bus_m.word_valid), 32'd1);
        words("t2", 4'b1011, 4'b1101);
        step(0, 0, 0);

        // Abort after two bits, restart with 0,1,0,1.
        step(1, 1, 1); step(1, 1, 0);
        chk("t3_count2", 32'(cnt_m), 32'd2);
        step(1, 0, 1);
        chk("t3_ferr", 32'({err_m, err_l}), 32'h3);
        chk("t3_count_restart", 32'(cnt_m), 32'd1);
        step(1, 1, 0);
        chk("t3_ferr_pulse", 32'({err_m, err_l}), 32'h0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("t3_valid", 32'(bus_m.word_valid), 32'd1);
        words("t3", 4'b0101, 4'b1010);
        step(0, 0, 0);
        chk("t3_valid_drop", 32'(bus_m.word_valid), 32'd0);

        // Downstream stalled: second word is dropped, overrun sticks.
        word_ready = 1'b0;
        frame(4'hA);
        chk("t4_valid_a", 32'(bus_m.word_valid), 32'd1);
        chk("t4_no_ovr_yet", 32'({ovr_m, ovr_l}), 32'h0);
        words("t4a", 4'hA, 4'h5);
        frame(4'h5);
        chk("t4_ovr", 32'({ovr_m, ovr_l}), 32'h3);
        words("t4b", 4'hA, 4'h5);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t4_ovr_sticky", 32'({ovr_m, ovr_l}), 32'h3);
        word_ready = 1'b1;
        step(0, 0, 0);
        chk("t4_valid_drop", 32'({bus_m.word_valid, bus_l.word_valid}), 32'h0);
        chk("t4_ovr_after_drain", 32'({ovr_m, ovr_l}), 32'h3);
        words("t4c", 4'hA, 4'h5);

        // Reset mid-frame, then a full frame 4'h6 held for a stalled consumer.
        word_ready = 1'b0;
        step(1, 1, 1); step(1, 1, 0);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        all_zero("t5_reset");
        frame(4'h6);
        chk("t5_valid", 32'(bus_m.word_valid), 32'd1);
        words("t5", 4'h6, 4'h6);
        step(0, 0, 0);
        chk("t5_hold", 32'({bus_m.word_valid, bus_l.word_valid}), 32'h3);

        // Completion coinciding with consumption: load replaces the held word.
        step(1, 1, 1); step(1, 0, 0); step(1, 0, 0);
        chk("t6_still_6", 32'(bus_m.word_out), 32'h6);
        word_ready = 1'b1;
        step(1, 1, 0);
        chk("t6_valid", 32'({bus_m.word_valid, bus_l.word_valid}), 32'h3);
        chk("t6_no_ovr", 32'({ovr_m, ovr_l}), 32'h0);
        words("t6", 4'h9, 4'h9);
        step(0, 0, 0);
        chk("t6_valid_drop", 32'(bus_m.word_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
